// File: rtl/bi_stream_decoder.sv
// Bipolar stochastic bitstream decoder.
// Counts ones over a window of 2^WINLOG valid bits and reports two results:
// the raw ones count k, and the signed bipolar value k - L/2.
module bi_stream_decoder #(
    parameter int unsigned WINLOG = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iBit,
    input  logic            iBitVld,
    input  logic            start,
    input  logic            clr,
    input  logic            iAck,
    output logic            busy,
    output logic            oValid,
    output logic [WINLOG:0] oCnt,
    output logic [WINLOG:0] oVal
);

    localparam int unsigned    HalfInt = 2 ** (WINLOG - 1);
    localparam logic [WINLOG:0] Half   = (WINLOG + 1)'(HalfInt);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e              state_q, state_d;
    logic [WINLOG-1:0]   wc_q, wc_d;      // valid bits accepted so far
    logic [WINLOG:0]     oc_q, oc_d;      // ones seen so far; one extra bit so k = L fits
    logic [WINLOG:0]     cnt_q, cnt_d;
    logic [WINLOG:0]     val_q, val_d;
    logic                valid_q, valid_d;
    logic [WINLOG:0]     bit_ext;
    logic [WINLOG:0]     fin_cnt;

    // Next-state and result computation; clr overrides everything else.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        oc_d    = oc_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        valid_d = valid_q;
        bit_ext = {{WINLOG{1'b0}}, iBit & iBitVld};
        fin_cnt = oc_q + bit_ext;

        if (clr) begin
            state_d = StIdle;
            wc_d    = '0;
            oc_d    = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (start) begin
                        // The start-cycle sample opens the window; counters are already zero.
                        state_d = StAcc;
                        valid_d = 1'b0;
                        wc_d    = wc_q + WINLOG'(iBitVld);
                        oc_d    = oc_q + bit_ext;
                    end else if (state_q == StHold && iAck) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end
                StAcc: begin
                    if (iBitVld) begin
                        if (wc_q == '1) begin
                            // L-th valid bit: publish result and wrap the counters.
                            state_d = StHold;
                            cnt_d   = fin_cnt;
                            val_d   = fin_cnt - Half;
                            valid_d = 1'b1;
                            wc_d    = '0;
                            oc_d    = '0;
                        end else begin
                            wc_d = wc_q + WINLOG'(1);
                            oc_d = fin_cnt;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and result registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wc_q    <= '0;
            oc_q    <= '0;
            cnt_q   <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            oc_q    <= oc_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            valid_q <= valid_d;
        end
    end

    assign busy   = (state_q == StAcc);
    assign oValid = valid_q;
    assign oCnt   = cnt_q;
    assign oVal   = val_q;

endmodule

// File: tb/tb_bi_stream_decoder.sv
// Self-checking bench for bi_stream_decoder (WINLOG = 8, L = 256).
// A window-level model tracks which valid bits belong to the open window and
// what result was last published; a negedge process compares it every cycle.
module tb_bi_stream_decoder;

    localparam int WL = 8;
    localparam int L  = 1 << WL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iBit, iBitVld, start, clr, iAck;
    logic          busy, oValid;
    logic [WL:0]   oCnt, oVal;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: is a window open, how many valid bits/ones it holds, last result.
    bit m_open;
    int m_bits;
    int m_ones;
    bit m_valid;
    int m_cnt;
    int m_val;

    bi_stream_decoder #(.WINLOG(WL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iBit   (iBit),
        .iBitVld(iBitVld),
        .start  (start),
        .clr    (clr),
        .iAck   (iAck),
        .busy   (busy),
        .oValid (oValid),
        .oCnt   (oCnt),
        .oVal   (oVal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_open  = 1'b0;
        m_bits  = 0;
        m_ones  = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_val   = 0;
    endtask

    // Effect of one clock edge, given the inputs present before it.
    task automatic model_step(input bit st, input bit cl, input bit ak, input bit v, input bit b);
        if (cl) begin
            m_open  = 1'b0;
            m_bits  = 0;
            m_ones  = 0;
            m_valid = 1'b0;
            return;
        end
        if (!m_open) begin
            if (st) begin
                m_open  = 1'b1;
                m_bits  = 0;
                m_ones  = 0;
                m_valid = 1'b0;
            end else if (m_valid && ak) begin
                m_valid = 1'b0;
            end
        end
        if (m_open && v) begin
            m_bits++;
            if (b) m_ones++;
            if (m_bits == L) begin
                m_cnt   = m_ones;
                m_val   = m_ones - L / 2;
                m_valid = 1'b1;
                m_open  = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model.
    task automatic cyc(input bit st, input bit cl, input bit ak, input bit v, input bit b);
        start   = st;
        clr     = cl;
        iAck    = ak;
        iBitVld = v;
        iBit    = b;
        @(posedge clk);
        model_step(st, cl, ak, v, b);
        #1;
    endtask

    task automatic do_reset();
        start = 0; clr = 0; iAck = 0; iBitVld = 0; iBit = 0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy",   int'(busy),          int'(m_open));
        chk("oValid", int'(oValid),        int'(m_valid));
        chk("oCnt",   int'(oCnt),          m_cnt);
        chk("oVal",   int'($signed(oVal)), m_val);
    end

    initial begin
        do_reset();
        chk("rst_oValid", int'(oValid), 0);
        chk("rst_oCnt",   int'(oCnt),   0);
        chk("rst_busy",   int'(busy),   0);

        // All ones: result appears exactly L cycles after start.
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < L - 1; i++) cyc(0, 0, 0, 1, 1);
        chk("t1_early_valid", int'(oValid), 0);
        cyc(0, 0, 0, 1, 1);
        chk("t1_valid", int'(oValid), 1);
        chk("t1_busy",  int'(busy),   0);
        chk("t1_cnt",   int'(oCnt),   256);
        chk("t1_val",   int'($signed(oVal)), 128);
        cyc(0, 0, 1, 0, 0);
        chk("t1_ack", int'(oValid), 0);

        // All zeros.
        cyc(1, 0, 0, 1, 0);
        for (int i = 1; i < L; i++) cyc(0, 0, 0, 1, 0);
        chk("t2_cnt0", int'(oCnt), 0);
        chk("t2_val0", int'(oVal), 'h180);
        cyc(0, 0, 1, 0, 0);

        // Alternating 1,0.
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < L; i++) cyc(0, 0, 0, 1, (i % 2) == 0);
        chk("t2_cnt_alt", int'(oCnt), 128);
        chk("t2_val_alt", int'($signed(oVal)), 0);
        cyc(0, 0, 1, 0, 0);

        // 50% valid duty; iBit=1 on every invalid cycle, alternating on valid ones.
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < 2 * L - 2; i++) begin
            if (i % 2 == 0) cyc(0, 0, 0, 1, ((i / 2) % 2) == 0);
            else            cyc(0, 0, 0, 0, 1);
        end
        chk("t3_early_valid", int'(oValid), 0);
        cyc(0, 0, 0, 1, 0);
        chk("t3_valid", int'(oValid), 1);
        chk("t3_cnt",   int'(oCnt),   128);

        // start+iAck in HOLD: immediate restart, start-cycle bit counted.
        cyc(1, 0, 1, 1, 1);
        chk("t4_valid_drop", int'(oValid), 0);
        chk("t4_busy",       int'(busy),   1);
        for (int i = 1; i < L; i++) cyc(0, 0, 0, 1, 1);
        chk("t4_cnt", int'(oCnt), 256);
        cyc(0, 0, 1, 0, 0);
        chk("t4_ack_idle", int'(busy), 0);
        chk("t4_keep_cnt", int'(oCnt), 256);

        // Reset mid-window, then a fresh window with ones every third bit.
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < 100; i++) cyc(0, 0, 0, 1, 1);
        do_reset();
        chk("t5_rst_cnt", int'(oCnt), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
        chk("t5_no_result", int'(oValid), 0);
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < L; i++) cyc(0, 0, 0, 1, (i % 3) == 0);
        chk("t5_cnt", int'(oCnt), 86);
        chk("t5_val", int'($signed(oVal)), -42);
        cyc(0, 0, 1, 0, 0);

        // clr+start in ACC aborts; a later window counts only its own bits.
        cyc(1, 0, 0, 1, 1);
        for (int i = 1; i < 50; i++) cyc(0, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 1);
        chk("t6_busy",  int'(busy),   0);
        chk("t6_valid", int'(oValid), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 0);
        for (int i = 1; i < L; i++) cyc(0, 0, 0, 1, i >= 200);
        chk("t6_cnt", int'(oCnt), 56);
        chk("t6_val", int'($signed(oVal)), -72);
        cyc(0, 1, 0, 0, 0);
        chk("t6_clr_hold_valid", int'(oValid), 0);
        chk("t6_clr_keep_cnt",   int'(oCnt),   56);

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bi_stream_decoder.md
Name: bi_stream_decoder

Overview:
Decodes a bipolar stochastic (unary) bitstream back into a binary value, i.e. the receive end of our binary-to-bitstream generators and kernels. It counts 1s over a fixed window of L = 2^WINLOG valid bits and reports two values:
- the raw ones count;
- the signed bipolar value k - L/2, where +L/2 represents +1.0 and -L/2 represents -1.0.

It sits at the output of a bipolar stochastic kernel so the bench and downstream binary logic can read results.

Parameters:
WINLOG, 8, log2 of window length L (L = 2^WINLOG valid bits per measurement); legal range 2..16.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
iBit  input  1  stochastic bitstream sample
iBitVld  input  1  iBit is valid this cycle; only valid cycles are counted
start  input  1  begin new measurement window (level-sampled)
clr  input  1  synchronous abort to IDLE
iAck  input  1  consumer acknowledges result; clears oValid
busy  output  1  high while in ACC
oValid  output  1  result registers hold a completed measurement
oCnt  output  WINLOG+1  ones count k, 0..L
oVal  output  WINLOG+1  signed two's complement k - L/2, range -L/2..+L/2

Behaviour:
Reset (rst_n low, asynchronous):
- FSM = IDLE; busy = 0, oValid = 0, oCnt = 0, oVal = 0; internal counters = 0.
- A reset mid-window discards the partial count; nothing is reported.

FSM states: IDLE, ACC, HOLD.
- IDLE:
  - start=1 -> ACC.
  - The start-cycle sample counts if iBitVld=1, so the window begins in the same cycle as start.
- ACC:
  - busy = 1.
  - On each cycle with iBitVld=1: window counter wc increments; ones counter oc increments when iBit=1.
  - start is ignored in ACC; no restart.
  - When the L-th valid bit is accepted (wc == L-1 and iBitVld), next edge: oCnt <= final k (including that bit), oVal <= k - L/2, oValid <= 1, wc/oc <= 0, state -> HOLD.
- HOLD:
  - oCnt/oVal stable, oValid = 1.
  - iAck=1 and start=0 -> oValid <= 0, state -> IDLE. oCnt/oVal keep their last value.
  - start=1 (with or without iAck) -> new window begins that cycle, same counting rule as IDLE; oValid <= 0 next edge; state -> ACC.
- clr=1 in any state: next edge state -> IDLE, wc = oc = 0, oValid = 0, busy = 0. clr has priority over start, iAck and window completion. oCnt/oVal are left unchanged.

Latency: with iBitVld held at 1 and start at cycle 0, bits from cycles 0..L-1 are counted and oValid rises at cycle L. Gaps in iBitVld stretch the window 1:1.

Width and arithmetic rules:
- oc is WINLOG+1 bits so that k = L is representable (no wrap).
- wc is WINLOG bits; it wraps to 0 exactly on completion.
- oVal is computed as oc minus the constant 2^(WINLOG-1), in signed WINLOG+1 bits; no saturation is needed.

Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. WINLOG=8; start at cycle 0; iBitVld=1; iBit=1 constantly -> oValid rises at cycle 256, oCnt=256, oVal=+128; busy low from cycle 256.
2. Same setup, iBit=0 constantly -> oCnt=0, oVal=-128 (9'h180). Then iBit alternating 1,0 -> oCnt=128, oVal=0.
3. iBitVld toggling 1,0 (50% duty) with iBit=1 only on valid cycles -> oValid at cycle 511 (L valid bits span 2L-1 cycles), oCnt=256. Bits presented on invalid cycles must not count.
4. In HOLD, assert start and iAck in the same cycle with iBit=1 -> oValid low next cycle, busy high, the start-cycle bit is counted; the next result has oCnt=256. Also: iAck alone -> IDLE, oCnt retains 256.
5. Assert rst_n low at cycle 100 of a window, release, then start -> no oValid from the aborted window; the fresh window reports the correct count for its own 256 bits only.
6. Assert clr and start together while in ACC at cycle 50 -> IDLE next cycle, busy=0, oValid=0. A later start yields a count covering only post-start bits.
